bg_writer: RTL

- Write-side counterpart of the background address generator: fills a 320x240 background region of the sprite/background memory.
- Accepts a raster-order pixel stream over a valid/ready handshake and issues one registered memory write per accepted pixel.
- Writes start at a map-dependent base offset, so the display path can later read the region back.
- Sits between the map loader (SD/flash/host stream) and the write port of the on-chip background memory.

---
 rtl/bg_writer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bg_writer.sv
// Background map writer: streams raster-order pixels into a 320x240 memory region at a map base.
// Optional constant-colour FILL mode is compiled in when BG_WRITER_FILL_EN is defined.
module bg_writer #(
  parameter int unsigned WIDTH   = 320,
  parameter int unsigned HEIGHT  = 240,
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned OFFSET0 = 1707,
  parameter int unsigned OFFSET1 = 78507
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              mapSelect,
  input  logic [DATA_W-1:0] pixIn,
  input  logic              pixValid,
`ifdef BG_WRITER_FILL_EN
  input  logic              fillEn,
  input  logic [DATA_W-1:0] fillColor,
`endif
  output logic              pixReady,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              wrEn,
  output logic              busy,
  output logic              done
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] XLast = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] Base0 = ADDR_W'(OFFSET0);
  localparam logic [ADDR_W-1:0] Base1 = ADDR_W'(OFFSET1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad
`ifdef BG_WRITER_FILL_EN
    , StFill
`endif
  } state_e;

  state_e            stateQ, stateD;
  logic [ADDR_W-1:0] addrCntQ, addrCntD;
  logic [XW-1:0]     xQ, xD;
  logic [YW-1:0]     yQ, yD;
  logic [ADDR_W-1:0] wrAddrQ, wrAddrD;
  logic [DATA_W-1:0] wrDataQ, wrDataD;
  logic              wrEnQ, wrEnD;
  logic              doneQ, doneD;
  logic              beat;
  logic [DATA_W-1:0] beatData;

  always_comb begin
    stateD   = stateQ;
    addrCntD = addrCntQ;
    xD       = xQ;
    yD       = yQ;
    wrAddrD  = wrAddrQ;
    wrDataD  = wrDataQ;
    wrEnD    = 1'b0;
    doneD    = 1'b0;
    beat     = 1'b0;
    beatData = pixIn;

    unique case (stateQ)
      StIdle: begin
        if (start) begin
          addrCntD = mapSelect ? Base1 : Base0;
          xD       = '0;
          yD       = '0;
          stateD   = StLoad;
`ifdef BG_WRITER_FILL_EN
          if (fillEn) stateD = StFill;
`endif
        end
      end
      StLoad: beat = pixValid;
`ifdef BG_WRITER_FILL_EN
      StFill: begin
        beat     = 1'b1;
        beatData = fillColor;
      end
`endif
      default: stateD = StIdle;
    endcase

    // Running address counter replaces base + y*WIDTH + x
    if (beat) begin
      wrAddrD  = addrCntQ;
      wrDataD  = beatData;
      wrEnD    = 1'b1;
      addrCntD = addrCntQ + 1'b1;
      if (xQ == XLast) begin
        xD = '0;
        yD = yQ + 1'b1;
        if (yQ == YLast) begin
          yD     = '0;
          stateD = StIdle;
          doneD  = 1'b1;
        end
      end else begin
        xD = xQ + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ   <= StIdle;
      addrCntQ <= '0;
      xQ       <= '0;
      yQ       <= '0;
      wrAddrQ  <= '0;
      wrDataQ  <= '0;
      wrEnQ    <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      addrCntQ <= addrCntD;
      xQ       <= xD;
      yQ       <= yD;
      wrAddrQ  <= wrAddrD;
      wrDataQ  <= wrDataD;
      wrEnQ    <= wrEnD;
      doneQ    <= doneD;
    end
  end

  assign pixReady = (stateQ == StLoad);
  assign busy     = (stateQ != StIdle);
  assign wrAddr   = wrAddrQ;
  assign wrData   = wrDataQ;
  assign wrEn     = wrEnQ;
  assign done     = doneQ;

endmodule
